// File: rtl/iq_pkg.sv
// rtl/iq_pkg.sv - instruction record type and default sizing shared by the instruction queue
package iq_pkg;

    localparam int IQ_DEPTH = 16;
    localparam int IQ_IN_W  = 2;
    localparam int IQ_OUT_W = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        is_br;
        logic        is_j;
        logic        is_ds;
    } inst_t;

    function automatic int unsigned popcnt(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/iq_dispatch_sel.sv
// rtl/iq_dispatch_sel.sv - forms the decode bundle from the oldest entries, keeping each branch with its delay slot
module iq_dispatch_sel
    import iq_pkg::*;
#(
    parameter int OUT_W = IQ_OUT_W
) (
    input  inst_t [OUT_W-1:0] ent_i,
    input  logic  [OUT_W-1:0] loaded_i,
    output inst_t [OUT_W-1:0] inst_o,
    output logic  [OUT_W-1:0] valid_o
);

    // Extra zero bit lets the last lane look one entry ahead without a range check.
    logic [OUT_W:0] loaded_ext;
    logic           stop;
    logic           ds_pend;

    assign loaded_ext = {1'b0, loaded_i};

    always_comb begin
        stop    = 1'b0;
        ds_pend = 1'b0;
        valid_o = '0;
        inst_o  = ent_i;
        for (int j = 0; j < OUT_W; j++) begin
            inst_o[j].is_ds = 1'b0;
            if (!stop && loaded_ext[j]) begin
                if (ds_pend) begin
                    valid_o[j]      = 1'b1;
                    inst_o[j].is_ds = 1'b1;
                    stop            = 1'b1;
                end else if (ent_i[j].is_br || ent_i[j].is_j) begin
                    if (loaded_ext[j+1]) begin
                        valid_o[j] = 1'b1;
                        ds_pend    = 1'b1;
                    end else begin
                        stop = 1'b1;
                    end
                end else begin
                    valid_o[j] = 1'b1;
                end
            end else begin
                stop = 1'b1;
            end
        end
    end

endmodule

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - fetch-to-decode instruction queue; define IQ_BYPASS_EN for empty-queue same-cycle bypass
module inst_queue
    import iq_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int IN_W  = IQ_IN_W,
    parameter int OUT_W = IQ_OUT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic  [IN_W-1:0]        in_valid,
    input  inst_t [IN_W-1:0]        in_inst,
    output logic                    pause_req,
    input  logic                    out_ready,
    output logic  [OUT_W-1:0]       out_valid,
    output inst_t [OUT_W-1:0]       out_inst,
    output logic  [$clog2(DEPTH):0] count
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int MW = (IN_W > OUT_W) ? IN_W : OUT_W;

    inst_t             mem_q [DEPTH];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d, count_q, count_d;
    inst_t [MW-1:0]    comp;
    logic [PW-1:0]     n_in, n_skip, n_enq, n_ret;
    inst_t [OUT_W-1:0] st_ent, st_inst, sel_inst;
    logic [OUT_W-1:0]  st_loaded, st_valid, sel_valid;
    logic              kill;

    assign count     = count_q;
    assign kill      = rst || flush;
    assign pause_req = (DEPTH - int'(count_q)) < IN_W;

    // Valid lanes packed down to slots 0..n_in-1, preserving lane order.
    always_comb begin
        int cnt;
        comp = '0;
        for (int k = 0; k < IN_W; k++) begin
            cnt = 0;
            for (int l = 0; l < IN_W; l++) begin
                if (in_valid[l]) begin
                    if (cnt == k) comp[k] = in_inst[l];
                    cnt = cnt + 1;
                end
            end
        end
    end

    assign n_in = PW'(popcnt(32'(in_valid)));

    always_comb begin
        for (int i = 0; i < OUT_W; i++) begin
            st_ent[i]    = mem_q[IW'(head_q[IW-1:0] + IW'(i))];
            st_loaded[i] = PW'(i) < count_q;
        end
    end

    iq_dispatch_sel #(.OUT_W(OUT_W)) u_sel_st (
        .ent_i    (st_ent),
        .loaded_i (st_loaded),
        .inst_o   (st_inst),
        .valid_o  (st_valid)
    );

`ifdef IQ_BYPASS_EN
    inst_t [OUT_W-1:0] by_ent, by_inst;
    logic [OUT_W-1:0]  by_loaded, by_valid;
    logic              bypass;

    always_comb begin
        for (int i = 0; i < OUT_W; i++) begin
            by_ent[i]    = comp[i];
            by_loaded[i] = PW'(i) < n_in;
        end
    end

    iq_dispatch_sel #(.OUT_W(OUT_W)) u_sel_by (
        .ent_i    (by_ent),
        .loaded_i (by_loaded),
        .inst_o   (by_inst),
        .valid_o  (by_valid)
    );

    // Lanes consumed straight from fetch are skipped when writing storage.
    assign bypass    = (count_q == '0) && out_ready && !pause_req && !kill;
    assign n_skip    = bypass ? PW'(popcnt(32'(by_valid))) : '0;
    assign sel_valid = bypass ? by_valid : st_valid;
    assign sel_inst  = bypass ? by_inst  : st_inst;
`else
    assign n_skip    = '0;
    assign sel_valid = st_valid;
    assign sel_inst  = st_inst;
`endif

    assign out_valid = sel_valid & {OUT_W{!kill}};
    assign out_inst  = sel_inst;

    assign n_enq = pause_req ? '0 : (n_in - n_skip);
    assign n_ret = (out_ready && !kill) ? PW'(popcnt(32'(st_valid))) : '0;

    always_comb begin
        head_d  = head_q + n_ret;
        tail_d  = tail_q + n_enq;
        count_d = count_q + n_enq - n_ret;
        if (kill) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!kill) begin
            for (int k = 0; k < IN_W; k++) begin
                if (PW'(k) >= n_skip && PW'(k) < n_skip + n_enq) begin
                    mem_q[IW'(tail_q[IW-1:0] + IW'(k) - n_skip[IW-1:0])] <= comp[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - scoreboard bench for inst_queue against a queue-based reference model
module tb_inst_queue;
    import iq_pkg::*;

    localparam int D  = 16;
    localparam int IW = 2;
    localparam int OW = 2;

    logic              clk;
    logic              rst;
    logic              flush;
    logic [IW-1:0]     in_valid;
    inst_t [IW-1:0]    in_inst;
    logic              pause_req;
    logic              out_ready;
    logic [OW-1:0]     out_valid;
    inst_t [OW-1:0]    out_inst;
    logic [$clog2(D):0] count;

    int    checks = 0;
    int    errors = 0;
    bit    done = 0;
    bit    started = 0;
    int    pc_ctr = 32'h1000;
    inst_t sb[$];

    inst_queue #(.DEPTH(D), .IN_W(IW), .OUT_W(OW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_inst   (in_inst),
        .pause_req (pause_req),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_inst  (out_inst),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic inst_t mk(input bit b);
        inst_t r;
        bit    jmp;
        jmp     = $urandom_range(0, 1) == 1;
        r.pc    = pc_ctr;
        r.inst  = $urandom;
        r.is_br = b && !jmp;
        r.is_j  = b && jmp;
        r.is_ds = $urandom_range(0, 1) == 1;
        pc_ctr  = pc_ctr + 4;
        return r;
    endfunction

    // Bundle rule: oldest-first, stop at a missing entry, a branch needs its delay slot in the next lane.
    function automatic int bundle(input inst_t lst[$], output bit [OW:0] ds);
        int n;
        n  = 0;
        ds = '0;
        for (int j = 0; j < OW; j++) begin
            if (j >= lst.size()) break;
            if (lst[j].is_br || lst[j].is_j) begin
                if (j + 1 < OW && j + 1 < lst.size()) begin
                    n         = j + 2;
                    ds[j + 1] = 1'b1;
                end
                break;
            end
            n = j + 1;
        end
        return n;
    endfunction

    task automatic model_step();
        inst_t         incoming[$];
        inst_t         lst[$];
        bit [OW:0]     ds;
        int            n;
        bit            byp;
        bit            paused;
        logic [OW-1:0] ev;
        for (int l = 0; l < IW; l++) begin
            if (in_valid[l]) incoming.push_back(in_inst[l]);
        end
        byp = 1'b0;
`ifdef IQ_BYPASS_EN
        byp = !rst && !flush && out_ready && sb.size() == 0;
`endif
        if (byp) lst = incoming;
        else     lst = sb;
        n  = bundle(lst, ds);
        ev = (rst || flush) ? '0 : OW'((1 << n) - 1);
        chk("out_valid", 64'(out_valid), 64'(ev));
        if (!(rst || flush)) begin
            for (int i = 0; i < n; i++) begin
                chk("lane_pc",   64'(out_inst[i].pc),   64'(lst[i].pc));
                chk("lane_inst", 64'(out_inst[i].inst), 64'(lst[i].inst));
                chk("lane_flags", 64'({out_inst[i].is_br, out_inst[i].is_j, out_inst[i].is_ds}),
                    64'({lst[i].is_br, lst[i].is_j, ds[i]}));
            end
        end
        if (started) begin
            chk("count", 64'(count), 64'(sb.size()));
            chk("pause_req", 64'(pause_req), 64'((D - sb.size()) < IW));
        end
        paused = (D - sb.size()) < IW;
        if (rst) begin
            sb.delete();
            started = 1'b1;
        end else if (flush) begin
            sb.delete();
        end else if (byp) begin
            for (int k = n; k < incoming.size(); k++) sb.push_back(incoming[k]);
        end else begin
            if (out_ready) begin
                for (int k = 0; k < n; k++) void'(sb.pop_front());
            end
            if (!paused) begin
                foreach (incoming[k]) sb.push_back(incoming[k]);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (done) break;
            model_step();
        end
    end

    task automatic drive(input logic [IW-1:0] v, input logic [IW-1:0] br, input bit rdy,
                         input bit fl, input bit rs);
        for (int l = 0; l < IW; l++) in_inst[l] = mk(br[l]);
        in_valid  = v;
        out_ready = rdy;
        flush     = fl;
        rst       = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rdy_pct;
        rst = 1'b1; flush = 1'b0; in_valid = '0; out_ready = 1'b0; in_inst = '0;
        repeat (3) drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);

        // Lane-order compaction while backend stalls.
        drive(2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
        drive(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        repeat (3) drive(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);

        // Fill to 15, overflow attempt ignored, one retire releases the stall.
        repeat (7) drive(2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
        drive(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        drive(2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
        drive(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        repeat (9) drive(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);

        // Branch at head waits three cycles for its delay slot.
        drive(2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
        repeat (3) drive(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        drive(2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
        repeat (2) drive(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);

        // ALU, BR, DS at head.
        drive(2'b11, 2'b10, 1'b0, 1'b0, 1'b0);
        drive(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        repeat (3) drive(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);

        // Flush with 9 entries and a simultaneous two-lane input.
        repeat (4) drive(2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
        drive(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        drive(2'b11, 2'b00, 1'b1, 1'b1, 1'b0);
        repeat (2) drive(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);

        // Empty queue, ready backend, two ALU lanes.
        drive(2'b11, 2'b00, 1'b1, 1'b0, 1'b0);
        repeat (2) drive(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);

        // Reset mid-operation with the queue partially full.
        repeat (3) drive(2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
        drive(2'b11, 2'b00, 1'b1, 1'b1, 1'b1);
        drive(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);

        rdy_pct = 70;
        for (int c = 0; c < 3000; c++) begin
            logic [IW-1:0] br;
            if (c % 200 == 0) rdy_pct = $urandom_range(10, 95);
            for (int l = 0; l < IW; l++) br[l] = $urandom_range(0, 3) == 0;
            drive(IW'($urandom), br, $urandom_range(0, 99) < rdy_pct,
                  $urandom_range(0, 99) == 0, $urandom_range(0, 299) == 0);
        end

        done = 1'b1;
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning entry count; power of 2 and >= 2*max(IN_W,OUT_W).
REQ-002 SHALL have parameter IN_W, default 2, meaning fetch lanes per cycle (>=1).
REQ-003 SHALL have parameter OUT_W, default 2, meaning decode lanes per cycle (>=2).
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush  input  1  backend redirect; discards all contents.
REQ-007 SHALL have port in_valid  input  IN_W  per-lane fetch valid; any bit pattern is legal.
REQ-008 SHALL have port in_inst  input  IN_W x inst_t  fetched instructions, lane 0 oldest.
REQ-009 SHALL have port pause_req  output  1  fetch stall request.
REQ-010 SHALL have port out_ready  input  1  backend accepts all presented lanes this cycle.
REQ-011 SHALL have port out_valid  output  OUT_W  per-lane presented valid, contiguous from lane 0.
REQ-012 SHALL have port out_inst  output  OUT_W x inst_t  presented instructions, is_ds resolved.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  registered occupancy.

Function
REQ-014 SHALL keep head/tail pointers of $clog2(DEPTH)+1 bits (wrap bit); empty = equal pointers, full = equal index with differing wrap bit; all index arithmetic modulo DEPTH.
REQ-015 SHALL drive pause_req = (DEPTH - count) < IN_W, combinationally from registered state only.
REQ-016 SHALL, when !pause_req, write the valid lanes of in_valid compacted in lane order at tail, advancing tail by popcount(in_valid); SHALL ignore input while pause_req=1.
REQ-017 SHALL form the presented bundle from the oldest entries, lane i = entry head+i, truncated at the first lane whose entry is not loaded.
REQ-018 SHALL present a branch/jump (is_br|is_j) in lane j only if j < OUT_W-1 and entry j+1 is loaded; that entry is presented in lane j+1 with is_ds=1 and all lanes > j+1 are invalid.
REQ-019 SHALL, when the branch condition of REQ-018 fails at lane j, truncate the bundle before lane j; a branch at lane 0 whose delay slot is absent yields out_valid=0 (wait for delay slot).
REQ-020 SHALL drive is_ds=0 on every lane not covered by REQ-018.
REQ-021 SHALL, when out_ready=1, retire exactly popcount(out_valid) entries, advancing head accordingly; nothing retires when out_ready=0.
REQ-022 SHALL update count by (enqueued - retired) when enqueue and retire coincide in one cycle.
REQ-023 SHALL force out_valid=0 combinationally in any cycle with rst=1 or flush=1.
REQ-024 SHALL, on flush, set head=tail=0 and count=0 next cycle, dropping same-cycle input and retiring nothing.

Reset
REQ-025 SHALL on rst set head=0, tail=0, count=0; consequently pause_req=0 and out_valid=0 from the next cycle; entry storage is not reset.
REQ-026 SHALL give rst priority over flush and over all enqueue/retire activity, including mid-operation with the queue partially full.

Configuration
REQ-027 SHALL, with IQ_BYPASS_EN defined, present incoming lanes combinationally (REQ-017..020 applied to in_inst) when the queue is empty, out_ready=1, pause_req=0 and no flush/rst; consumed lanes are not written, unconsumed valid lanes are written at tail.
REQ-028 SHALL, without IQ_BYPASS_EN, have minimum fetch-to-output latency of one cycle, with no combinational path from in_* to out_*.

Structure
REQ-029 SHALL take inst_t (pc[31:0], inst[31:0], is_br, is_j, is_ds) from shared package iq_pkg, which also holds the default DEPTH/IN_W/OUT_W constants.
REQ-030 SHALL place bundle formation (REQ-017..020) in one combinational sub-module iq_dispatch_sel, instantiated for the stored path and, under IQ_BYPASS_EN, the bypass path.

Verification (DEPTH=16, IN_W=2, OUT_W=2)
REQ-031 SHALL cover in_valid=2'b10 then 2'b01 with out_ready=0 -> count=1 then 2, entries in lane order.
REQ-032 SHALL cover a fill to 15 entries -> pause_req=1 and a further 2-lane input ignored; retire 2 -> pause_req=0.
REQ-033 SHALL cover a branch at head with its delay slot arriving 3 cycles later -> out_valid=00 for those 3 cycles, then 11 with lane1 is_ds=1.
REQ-034 SHALL cover head entries {ALU, BR, DS} -> first bundle out_valid=01 (ALU only), next bundle BR+DS.
REQ-035 SHALL cover flush with count=9 and simultaneous 2-lane input -> out_valid=0 that cycle, count=0 next, input dropped.
REQ-036 SHALL cover, with IQ_BYPASS_EN, an empty queue, out_ready=1 and in={ALU,ALU} -> same-cycle out_valid=11 and count stays 0.
